lbist_boot_sequencer: RTL and testbench
=======================================

Name: lbist_boot_sequencer

Overview:
- Sequences the core's LBIST test inputs and boot handshake at power-on.
- Holds the core, runs logic BIST through test_mode/test_mode_tp/normal_test, waits for test_over, and evaluates go_nogo.
- Supports bounded retries with a timeout.
- On pass (or when BIST is skipped), releases the core and raises fetch_enable. It sits between the top-level reset/boot control and the core wrapper's test ports.

Parameters:
SETUP_CYCLES, 4, cycles with test controls asserted before RUN (>=1)
TIMEOUT_CYCLES, 4096, max RUN cycles awaiting test_over (1..2^TO_W)
TO_W, 16, width of the cycle counter
MAX_ATTEMPTS, 2, total BIST attempts before FAILED (>=1)
RELEASE_CYCLES, 2, functional-mode cycles with core out of reset before fetch_enable (>=1)
AW, 4, width of attempts_o

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
start_i  in  1  level; sampled in IDLE only
skip_i  in  1  with start_i: bypass BIST
test_over_i  in  1  from core; BIST finished
go_nogo_i  in  1  from core; 1 = signature match
test_mode_o  out  1  to core test_mode_i
test_mode_tp_o  out  1  to core test_mode_tp_i
normal_test_o  out  1  to core normal_test_i
clock_en_o  out  1  to core clock_en_i
core_rst_no  out  1  core reset, active-low
fetch_enable_o  out  1  to core fetch_enable_i
busy_o  out  1  state in SETUP/RUN/EVAL/RELEASE
done_o  out  1  state in ACTIVE/FAILED
pass_o  out  1  sticky; last attempt passed
fail_o  out  1  sticky; attempts exhausted
timeout_o  out  1  sticky; any attempt timed out
attempts_o  out  AW  attempts started

Behaviour:
- Reset (async, rst_ni=0): state IDLE, every output 0, counters 0, test_over_q 0, result 0.
- test_over_q registers test_over_i every cycle in every state. Edge = test_over_i & ~test_over_q.
- All outputs are registered or decoded from the state register. Transitions occur on the clk_i rising edge.

IDLE:
- Test outputs 0, clock_en_o 0, core_rst_no 0.
- start_i=1 & skip_i=1 -> RELEASE; counter = RELEASE_CYCLES-1.
- start_i=1 & skip_i=0 -> SETUP; counter = SETUP_CYCLES-1; attempts_o += 1.

SETUP:
- test_mode_o = test_mode_tp_o = normal_test_o = clock_en_o = core_rst_no = 1.
- counter==0 -> RUN, counter cleared; else decrement.

RUN:
- Outputs as in SETUP. Counter increments each cycle.
- Edge -> EVAL; result = go_nogo_i sampled that cycle.
- Else, if counter==TIMEOUT_CYCLES-1 -> EVAL; result = 0; timeout_o = 1.
- Edge on the final timeout cycle: the edge wins and timeout_o is not set.
- A test_over_i already high on RUN entry is not an edge.

EVAL (1 cycle):
- Test outputs 0, core_rst_no 0, clock_en_o 1.
- result=1 -> RELEASE; pass_o = 1; counter = RELEASE_CYCLES-1.
- result=0 and attempts_o < MAX_ATTEMPTS -> SETUP; attempts_o += 1.
- Otherwise -> FAILED; fail_o = 1.

RELEASE:
- Test outputs 0, clock_en_o 1, core_rst_no 1.
- Counter down; at 0 -> ACTIVE.

ACTIVE:
- fetch_enable_o 1, clock_en_o 1, core_rst_no 1.
- Terminal until reset; start_i ignored.

FAILED:
- clock_en_o 0, core_rst_no 0, fetch_enable_o 0.
- Terminal until reset.

Other rules:
- attempts_o saturates at 2^AW-1.
- pass_o and fail_o are mutually exclusive.
- Skip path leaves pass_o = 0.
- Latency, start to first test cycle: test outputs high 1 cycle after start_i is sampled.
- Latency, EVAL pass to fetch_enable_o: 1 + RELEASE_CYCLES cycles.

Optional Feature:
LBIST_CYCLE_COUNT_EN:
- When defined, adds output run_cycles_o [TO_W-1:0].
- run_cycles_o latches the RUN counter value +1 on every RUN->EVAL transition (the RUN duration of the last attempt). Reset 0.
- When undefined, the port and its register are absent; the counter serves only the timeout.

Test Plan:
1. Defaults; start_i=1; test_over_i rises on RUN cycle 10 with go_nogo_i=1 -> pass_o=1, attempts_o=1; fetch_enable_o high 3 cycles after EVAL; run_cycles_o=10 if LBIST_CYCLE_COUNT_EN.
2. MAX_ATTEMPTS=2; first edge with go_nogo_i=0, second with go_nogo_i=1 -> EVAL, then SETUP again; final pass_o=1, attempts_o=2, fail_o=0.
3. MAX_ATTEMPTS=2; go_nogo_i=0 on both attempts -> FAILED; fail_o=1, done_o=1, core_rst_no=0, fetch_enable_o=0 indefinitely.
4. TIMEOUT_CYCLES=16, test_over_i held 0 -> EVAL after 16 RUN cycles, timeout_o=1. Repeat with the edge on RUN cycle 16 -> timeout_o=0, result=go_nogo_i.
5. start_i=1, skip_i=1 -> no test output ever high; fetch_enable_o high 1+RELEASE_CYCLES cycles later; pass_o=0, attempts_o=0.
6. Assert rst_ni=0 mid-RUN (not clock-aligned) -> all outputs 0 immediately; after release, IDLE and attempts_o=0; a new start_i runs a full sequence.

Source files
------------

// File: rtl/lbist_boot_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lbist_boot_sequencer : power-on LBIST sequencing and core boot handshake.
// Rev 1.0 -- optional LBIST_CYCLE_COUNT_EN adds run_cycles_o.
// ---------------------------------------------------------------------------
module lbist_boot_sequencer #(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 16,
  parameter int MAX_ATTEMPTS   = 2,
  parameter int RELEASE_CYCLES = 2,
  parameter int AW             = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          skip_i,
  input  logic          test_over_i,
  input  logic          go_nogo_i,
  output logic          test_mode_o,
  output logic          test_mode_tp_o,
  output logic          normal_test_o,
  output logic          clock_en_o,
  output logic          core_rst_no,
  output logic          fetch_enable_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic          fail_o,
  output logic          timeout_o,
  output logic [AW-1:0] attempts_o
`ifdef LBIST_CYCLE_COUNT_EN
  ,
  output logic [TO_W-1:0] run_cycles_o
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    RUN     = 3'd2,
    EVAL    = 3'd3,
    RELEASE = 3'd4,
    ACTIVE  = 3'd5,
    FAILED  = 3'd6
  } state_t;

  localparam logic [TO_W-1:0] SETUP_LOAD = TO_W'(SETUP_CYCLES - 1);
  localparam logic [TO_W-1:0] REL_LOAD   = TO_W'(RELEASE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0]   ATT_MAX    = '1;

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic [AW-1:0]   attempts, attempts_nxt, attempts_inc;
  logic            test_over_q, over_edge, more_tries;
  logic            result, result_nxt;
  logic            pass, pass_nxt, fail, fail_nxt, timeout, timeout_nxt;

  assign over_edge    = test_over_i & ~test_over_q;
  assign attempts_inc = (attempts == ATT_MAX) ? attempts : attempts + AW'(1);
  assign more_tries   = int'(attempts) < MAX_ATTEMPTS;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      attempts    <= '0;
      test_over_q <= 1'b0;
      result      <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      attempts    <= attempts_nxt;
      test_over_q <= test_over_i;
      result      <= result_nxt;
      pass        <= pass_nxt;
      fail        <= fail_nxt;
      timeout     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    attempts_nxt   = attempts;
    result_nxt     = result;
    pass_nxt       = pass;
    fail_nxt       = fail;
    timeout_nxt    = timeout;
    test_mode_o    = 1'b0;
    test_mode_tp_o = 1'b0;
    normal_test_o  = 1'b0;
    clock_en_o     = 1'b0;
    core_rst_no    = 1'b0;
    fetch_enable_o = 1'b0;
    busy_o         = 1'b0;
    done_o         = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (skip_i) begin
            state_nxt = RELEASE;
            cnt_nxt   = REL_LOAD;
          end else begin
            state_nxt    = SETUP;
            cnt_nxt      = SETUP_LOAD;
            attempts_nxt = attempts_inc;
          end
        end
      end
      SETUP: begin
        {test_mode_o, test_mode_tp_o, normal_test_o} = 3'b111;
        clock_en_o  = 1'b1;
        core_rst_no = 1'b1;
        busy_o      = 1'b1;
        if (cnt == '0) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - TO_W'(1);
        end
      end
      RUN: begin
        {test_mode_o, test_mode_tp_o, normal_test_o} = 3'b111;
        clock_en_o  = 1'b1;
        core_rst_no = 1'b1;
        busy_o      = 1'b1;
        cnt_nxt     = cnt + TO_W'(1);
        // A completion edge on the last allowed cycle beats the timeout.
        if (over_edge) begin
          state_nxt  = EVAL;
          result_nxt = go_nogo_i;
        end else if (cnt == TO_LAST) begin
          state_nxt   = EVAL;
          result_nxt  = 1'b0;
          timeout_nxt = 1'b1;
        end
      end
      EVAL: begin
        clock_en_o = 1'b1;
        busy_o     = 1'b1;
        if (result) begin
          state_nxt = RELEASE;
          pass_nxt  = 1'b1;
          cnt_nxt   = REL_LOAD;
        end else if (more_tries) begin
          state_nxt    = SETUP;
          cnt_nxt      = SETUP_LOAD;
          attempts_nxt = attempts_inc;
        end else begin
          state_nxt = FAILED;
          fail_nxt  = 1'b1;
        end
      end
      RELEASE: begin
        clock_en_o  = 1'b1;
        core_rst_no = 1'b1;
        busy_o      = 1'b1;
        if (cnt == '0) state_nxt = ACTIVE;
        else           cnt_nxt   = cnt - TO_W'(1);
      end
      ACTIVE: begin
        fetch_enable_o = 1'b1;
        clock_en_o     = 1'b1;
        core_rst_no    = 1'b1;
        done_o         = 1'b1;
      end
      FAILED: begin
        done_o = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pass_o     = pass;
  assign fail_o     = fail;
  assign timeout_o  = timeout;
  assign attempts_o = attempts;

`ifdef LBIST_CYCLE_COUNT_EN
  logic [TO_W-1:0] run_cycles;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               run_cycles <= '0;
    else if (state == RUN && state_nxt == EVAL) run_cycles <= cnt + TO_W'(1);
  end

  assign run_cycles_o = run_cycles;
`else
  // Without the feature the RUN counter only feeds the timeout compare.
`endif

endmodule
`default_nettype wire

// File: tb/tb_lbist_boot_sequencer.sv
`default_nettype none
// tb_lbist_boot_sequencer: directed and random boot sessions checked per cycle
// against a timeline model built from phase durations.
module tb_lbist_boot_sequencer;
  localparam int SC   = 4;
  localparam int T    = 16;
  localparam int MAXA = 2;
  localparam int RC   = 2;
  localparam int AW   = 4;
  localparam int TO_W = 16;
  localparam int VW   = 11 + AW;

  logic clk = 1'b0;
  logic rst_n, start, skip, tover, go;
  logic test_mode, test_mode_tp, normal_test, clock_en, core_rst_n, fetch_enable;
  logic busy, done, pass, fail, timeout;
  logic [AW-1:0] attempts;
`ifdef LBIST_CYCLE_COUNT_EN
  logic [TO_W-1:0] run_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int sess   = 0;
  int exp_run;
  int ek [MAXA];
  bit eg [MAXA];

  typedef struct packed {
    logic [7:0]    ph;
    logic          tov;
    logic          go;
    logic [AW-1:0] att;
    logic          p;
    logic          f;
    logic          to;
  } ent_t;
  ent_t sched[$];

  always #5 clk = ~clk;

  lbist_boot_sequencer #(
    .SETUP_CYCLES(SC), .TIMEOUT_CYCLES(T), .TO_W(TO_W),
    .MAX_ATTEMPTS(MAXA), .RELEASE_CYCLES(RC), .AW(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .skip_i(skip),
    .test_over_i(tover), .go_nogo_i(go),
    .test_mode_o(test_mode), .test_mode_tp_o(test_mode_tp), .normal_test_o(normal_test),
    .clock_en_o(clock_en), .core_rst_no(core_rst_n), .fetch_enable_o(fetch_enable),
    .busy_o(busy), .done_o(done), .pass_o(pass), .fail_o(fail), .timeout_o(timeout),
    .attempts_o(attempts)
`ifdef LBIST_CYCLE_COUNT_EN
    , .run_cycles_o(run_cycles)
`endif
  );

  function automatic ent_t mk(input logic [7:0] ph, input logic tv, input logic g,
                              input int att, input logic p, input logic f, input logic to);
    ent_t e;
    e.ph = ph; e.tov = tv; e.go = g; e.att = AW'(att);
    e.p = p; e.f = f; e.to = to;
    return e;
  endfunction

  // Output table per phase: S=setup R=run E=eval L=release A=active F=failed.
  function automatic logic [VW-1:0] exp_vec(input ent_t e);
    logic s, r, ev, l, a, fl;
    s = (e.ph == "S"); r = (e.ph == "R"); ev = (e.ph == "E");
    l = (e.ph == "L"); a = (e.ph == "A"); fl = (e.ph == "F");
    return {s | r, s | r, s | r, s | r | ev | l | a, s | r | l | a, a,
            s | r | ev | l, a | fl, e.p, e.f, e.to, e.att};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {test_mode, test_mode_tp, normal_test, clock_en, core_rst_n, fetch_enable,
            busy, done, pass, fail, timeout, attempts};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic build(input bit sk);
    int att, len;
    logic p, f, to;
    bit hit, held;
    att = 0; p = 0; f = 0; to = 0;
    sched.delete();
    exp_run = 0;
    if (sk) begin
      for (int i = 0; i < RC; i++) sched.push_back(mk("L", 1'b0, 1'($urandom), att, p, f, to));
    end else begin
      for (int a = 0; a < MAXA; a++) begin
        hit  = (ek[a] >= 1 && ek[a] <= T);
        held = (ek[a] < 0);
        len  = hit ? ek[a] : T;
        att  = (att < 2**AW - 1) ? att + 1 : att;
        for (int i = 0; i < SC; i++)
          sched.push_back(mk("S", held, 1'($urandom), att, p, f, to));
        for (int k = 1; k <= len; k++) begin
          if (hit && k == ek[a]) sched.push_back(mk("R", 1'b1, eg[a], att, p, f, to));
          else                   sched.push_back(mk("R", held, 1'($urandom), att, p, f, to));
        end
        if (!hit) to = 1'b1;
        sched.push_back(mk("E", 1'b0, 1'($urandom), att, p, f, to));
        exp_run = len;
        if (hit && eg[a]) begin
          p = 1'b1;
          for (int i = 0; i < RC; i++) sched.push_back(mk("L", 1'b0, 1'($urandom), att, p, f, to));
          break;
        end
        if (a == MAXA - 1) f = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++)
      sched.push_back(mk(f ? "F" : "A", 1'($urandom), 1'($urandom), att, p, f, to));
  endtask

  task automatic run_session(input bit sk, input int stop_at);
    sess++;
    build(sk);
    start = 1'b1; skip = sk; tover = 1'b0; go = 1'($urandom);
    for (int i = 0; i < sched.size(); i++) begin
      if (i == stop_at) return;
      @(posedge clk); #1;
      chk($sformatf("s%0d_c%0d_%s", sess, i, sched[i].ph), 32'(act_vec()), 32'(exp_vec(sched[i])));
      tover = sched[i].tov; go = sched[i].go;
      start = 1'($urandom); skip = 1'($urandom);
    end
`ifdef LBIST_CYCLE_COUNT_EN
    chk($sformatf("s%0d_run_cycles", sess), 32'(run_cycles), 32'(exp_run));
`endif
  endtask

  task automatic do_reset();
    #2; rst_n = 1'b0;
    #1; chk($sformatf("s%0d_async_rst", sess), 32'(act_vec()), 32'd0);
    start = 1'b0; skip = 1'b0; tover = 1'b0; go = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("s%0d_idle", sess), 32'(act_vec()), 32'd0);
`ifdef LBIST_CYCLE_COUNT_EN
    chk($sformatf("s%0d_run_cycles_rst", sess), 32'(run_cycles), 32'd0);
`endif
  endtask

  task automatic set_att(input int k0, input bit g0, input int k1, input bit g1);
    ek[0] = k0; eg[0] = g0; ek[1] = k1; eg[1] = g1;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; start = 1'b0; skip = 1'b0; tover = 1'b0; go = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_idle", 32'(act_vec()), 32'd0);

    set_att(10, 1, 0, 0);  run_session(1'b0, -1); do_reset();
    set_att(7, 0, 5, 1);   run_session(1'b0, -1); do_reset();
    set_att(4, 0, 9, 0);   run_session(1'b0, -1); do_reset();
    set_att(0, 0, 0, 0);   run_session(1'b0, -1); do_reset();
    set_att(16, 1, 0, 0);  run_session(1'b0, -1); do_reset();
    set_att(-1, 1, 16, 0); run_session(1'b0, -1); do_reset();
    set_att(17, 1, 1, 1);  run_session(1'b0, -1); do_reset();
    run_session(1'b1, -1); do_reset();
    set_att(12, 1, 0, 0);  run_session(1'b0, SC + 5); do_reset();
    set_att(10, 1, 0, 0);  run_session(1'b0, -1); do_reset();

    for (int n = 0; n < 30; n++) begin
      for (int a = 0; a < MAXA; a++) begin
        r = $urandom_range(0, T + 3);
        ek[a] = (r == T + 3) ? -1 : r;
        eg[a] = 1'($urandom);
      end
      run_session($urandom_range(0, 7) == 0, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 30) : -1);
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
